// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types, sizes and helpers for the main-memory controller
//            that sits on the bus side of the snooping MSI caches.
// Contents : NPROC / ADDR_W / DATA_W / MEM_DEPTH / PTR_W sizes, the FSM state
//            enum, a mod-3 pointer increment and a one-hot to index encoder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int NPROC     = 3;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 3;
  localparam int MEM_DEPTH = 8;
  localparam int PTR_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Round-robin pointer step: 0 -> 1 -> 2 -> 0.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Encode a one-hot (or zero) grant into a port index; zero maps to 0.
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NPROC-1:0] oh);
    logic [PTR_W-1:0] r;
    case (oh)
      3'b010:  r = 2'd1;
      3'b100:  r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr
// Purpose  : Combinational 3-way round-robin picker. Grants the first pending
//            port at or after ptr, scanning ptr, ptr+1, ptr+2 (mod 3).
// Ports    : pend  [2:0] in  - pending request vector
//            ptr   [1:0] in  - round-robin start position (0..2)
//            grant [2:0] out - one-hot grant (zero when nothing pending)
//            any         out - at least one request pending
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr
  import mem_pkg::*;
(
  input  logic [NPROC-1:0] pend,
  input  logic [PTR_W-1:0] ptr,
  output logic [NPROC-1:0] grant,
  output logic             any
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    grant = '0;
    w_idx = ptr;
    for (int k = 0; k < NPROC; k++) begin
      if ((grant == '0) && pend[w_idx]) begin
        grant[w_idx] = 1'b1;
      end
      w_idx = rr_next(w_idx);
    end
  end

  assign any = |pend;

endmodule
`default_nettype wire

// File: rtl/controlador_memoria.sv
`default_nettype none
// ============================================================================
// Module   : controlador_memoria
// Purpose  : Shared main-memory controller. Captures write-back and read-miss
//            requests from three caches, services write-backs before reads
//            with round-robin fairness, commits write-backs to an 8 x 3-bit
//            memory and returns read data after MEM_LAT cycles.
// Ports    : clock, reset (async, active-high)
//            wb_req/wb_addr/wb_data - per-port write-back request (3-bit fields)
//            rd_req/rd_addr         - per-port read request
//            rd_data   - per-port returned data, held until the next read
//            rd_valid  - 1-cycle pulse when rd_data[p] was updated
//            wb_done   - 1-cycle pulse when port p's write-back committed
//            erro      - sticky per-port overflow (dropped request) flag
//            busy      - high from the grant edge through the commit edge
// Revision : 1.0 - initial release
// ============================================================================
module controlador_memoria #(
  parameter int MEM_LAT = 2,
  parameter int NPROC   = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NPROC-1:0]                    wb_req,
  input  logic [NPROC*mem_pkg::ADDR_W-1:0]    wb_addr,
  input  logic [NPROC*mem_pkg::DATA_W-1:0]    wb_data,
  input  logic [NPROC-1:0]                    rd_req,
  input  logic [NPROC*mem_pkg::ADDR_W-1:0]    rd_addr,
  output logic [NPROC*mem_pkg::DATA_W-1:0]    rd_data,
  output logic [NPROC-1:0]                    rd_valid,
  output logic [NPROC-1:0]                    wb_done,
  output logic [NPROC-1:0]                    erro,
  output logic                                busy
);

  import mem_pkg::*;

  localparam int c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

  // Request capture state
  logic [NPROC-1:0]  r_wb_req_q, r_rd_req_q;
  logic [NPROC-1:0]  r_wb_pend, r_rd_pend;
  logic [NPROC-1:0]  r_erro;
  logic [ADDR_W-1:0] r_wb_addr [NPROC];
  logic [DATA_W-1:0] r_wb_data [NPROC];
  logic [ADDR_W-1:0] r_rd_addr [NPROC];

  // Service state
  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_port;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_data;
  logic [NPROC*DATA_W-1:0] r_rd_data;
  logic [NPROC-1:0]     r_rd_valid, r_wb_done;
  logic                 r_busy;
  logic [DATA_W-1:0]    r_mem [MEM_DEPTH];

  logic [NPROC-1:0] w_wb_edge, w_rd_edge;
  logic [NPROC-1:0] w_wb_gnt, w_rd_gnt;
  logic             w_wb_any, w_rd_any;
  logic             w_take_wb, w_take_rd;
  logic [PTR_W-1:0] w_wb_idx, w_rd_idx;
  logic [NPROC-1:0] w_wb_clr, w_rd_clr;

  assign w_wb_edge = wb_req & ~r_wb_req_q;
  assign w_rd_edge = rd_req & ~r_rd_req_q;

  arbitro_rr u_arb_wb (
    .pend  (r_wb_pend),
    .ptr   (r_ptr),
    .grant (w_wb_gnt),
    .any   (w_wb_any)
  );

  arbitro_rr u_arb_rd (
    .pend  (r_rd_pend),
    .ptr   (r_ptr),
    .grant (w_rd_gnt),
    .any   (w_rd_any)
  );

  // Write-backs always win over reads so evicted dirty blocks land first.
  assign w_take_wb = (r_state == IDLE) && w_wb_any;
  assign w_take_rd = (r_state == IDLE) && !w_wb_any && w_rd_any;
  assign w_wb_idx  = onehot_idx(w_wb_gnt);
  assign w_rd_idx  = onehot_idx(w_rd_gnt);
  assign w_wb_clr  = w_take_wb ? w_wb_gnt : '0;
  assign w_rd_clr  = w_take_rd ? w_rd_gnt : '0;

  // Edge capture. An edge that finds its pend bit still set (including the
  // cycle it is being granted) is dropped and flagged; latched values stay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_req_q <= '0;
      r_rd_req_q <= '0;
      r_wb_pend  <= '0;
      r_rd_pend  <= '0;
      r_erro     <= '0;
      for (int p = 0; p < NPROC; p++) begin
        r_wb_addr[p] <= '0;
        r_wb_data[p] <= '0;
        r_rd_addr[p] <= '0;
      end
    end else begin
      r_wb_req_q <= wb_req;
      r_rd_req_q <= rd_req;
      r_wb_pend  <= (r_wb_pend & ~w_wb_clr) | (w_wb_edge & ~r_wb_pend);
      r_rd_pend  <= (r_rd_pend & ~w_rd_clr) | (w_rd_edge & ~r_rd_pend);
      r_erro     <= r_erro | (w_wb_edge & r_wb_pend) | (w_rd_edge & r_rd_pend);
      for (int p = 0; p < NPROC; p++) begin
        if (w_wb_edge[p] && !r_wb_pend[p]) begin
          r_wb_addr[p] <= wb_addr[p*ADDR_W +: ADDR_W];
          r_wb_data[p] <= wb_data[p*DATA_W +: DATA_W];
        end
        if (w_rd_edge[p] && !r_rd_pend[p]) begin
          r_rd_addr[p] <= rd_addr[p*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Service FSM and memory. busy is registered so it also covers the commit
  // edge itself, dropping only on the idle cycle that follows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_port     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_wb_done  <= '0;
      r_busy     <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= DATA_W'(i);
      end
    end else begin
      r_rd_valid <= '0;
      r_wb_done  <= '0;
      case (r_state)
        IDLE: begin
          r_busy <= w_take_wb | w_take_rd;
          if (w_take_wb) begin
            r_state <= WRITE;
            r_port  <= w_wb_idx;
            r_addr  <= r_wb_addr[w_wb_idx];
            r_data  <= r_wb_data[w_wb_idx];
            r_cnt   <= c_CNT_LOAD;
            r_ptr   <= rr_next(w_wb_idx);
          end else if (w_take_rd) begin
            r_state <= READ;
            r_port  <= w_rd_idx;
            r_addr  <= r_rd_addr[w_rd_idx];
            r_cnt   <= c_CNT_LOAD;
            r_ptr   <= rr_next(w_rd_idx);
          end
        end
        WRITE: begin
          r_busy <= 1'b1;
          if (r_cnt == '0) begin
            r_mem[r_addr]     <= r_data;
            r_wb_done[r_port] <= 1'b1;
            r_state           <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        READ: begin
          r_busy <= 1'b1;
          if (r_cnt == '0) begin
            for (int p = 0; p < NPROC; p++) begin
              if (r_port == 2'(p)) begin
                r_rd_data[p*DATA_W +: DATA_W] <= r_mem[r_addr];
              end
            end
            r_rd_valid[r_port] <= 1'b1;
            r_state            <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign wb_done  = r_wb_done;
  assign erro     = r_erro;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_controlador_memoria.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_memoria
// Purpose  : Self-checking bench for controlador_memoria (MEM_LAT = 2).
//            Expected completions are queued when requests are driven and
//            popped by a monitor as rd_valid / wb_done pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_memoria;

  localparam int MEM_LAT = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] wb_req, rd_req;
  logic [8:0] wb_addr, wb_data, rd_addr;
  logic [8:0] rd_data;
  logic [2:0] rd_valid, wb_done, erro;
  logic       busy;

  controlador_memoria #(.MEM_LAT(MEM_LAT), .NPROC(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .wb_req   (wb_req),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wb_done  (wb_done),
    .erro     (erro),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_rd;
    int         port;
    logic [2:0] data;
  } exp_t;

  exp_t       sb[$];
  int         ev_t[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] m [8];

  always @(posedge clock) cyc++;

  // Completion monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && ((rd_valid | wb_done) != 3'b000)) begin
      n_cmp++;
      if (!$onehot({rd_valid, wb_done})) begin
        n_err++;
        $display("FAIL pulse_onehot: rd_valid=%b wb_done=%b, required a single pulse", rd_valid, wb_done);
      end
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < 2; k++) begin
          if ((k == 0) ? wb_done[p] : rd_valid[p]) begin
            ev_t.push_back(cyc);
            n_cmp++;
            if (sb.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_pulse: %s port %0d at cycle %0d, required none",
                       (k == 1) ? "rd_valid" : "wb_done", p, cyc);
            end else begin
              mon_e = sb.pop_front();
              if (mon_e.is_rd !== (k == 1) || mon_e.port != p ||
                  (k == 1 && rd_data[3*p +: 3] !== mon_e.data)) begin
                n_err++;
                $display("FAIL completion: got %s port %0d data %0d, required %s port %0d data %0d",
                         (k == 1) ? "rd" : "wb", p, rd_data[3*p +: 3],
                         mon_e.is_rd ? "rd" : "wb", mon_e.port, mon_e.data);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_rd(input int p, input int a);
    exp_t e;
    e.is_rd = 1'b1; e.port = p; e.data = m[a];
    sb.push_back(e);
  endtask

  task automatic push_wb(input int p, input int a, input logic [2:0] d);
    exp_t e;
    e.is_rd = 1'b0; e.port = p; e.data = d;
    sb.push_back(e);
    m[a] = d;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset  = 1'b1;
    wb_req = '0;
    rd_req = '0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 3'(i);
  endtask

  // Waits for the scoreboard to empty; counts busy cycles seen meanwhile.
  task automatic drain(input int maxc, output int busy_n);
    int c;
    c = 0;
    busy_n = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(negedge clock);
      #1;
      c++;
      if (busy) busy_n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d completions outstanding after %0d cycles, required 0", sb.size(), maxc);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_req = '0; rd_req = '0; wb_addr = '0; wb_data = '0; rd_addr = '0;
    #1;
    n_cmp++;
    if ({rd_data, rd_valid, wb_done, erro, busy} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0", {rd_data, rd_valid, wb_done, erro, busy});
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 3'(i);
    repeat (2) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || erro !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b erro=%b, required 0/000", busy, erro);
    end
  endtask

  task automatic test_read_basic();
    int t0, bn;
    @(negedge clock);
    ev_t.delete();
    rd_req[0] = 1'b1; rd_addr[2:0] = 3'd5;
    push_rd(0, 5);
    t0 = cyc;
    @(negedge clock);
    rd_req[0] = 1'b0;
    drain(20, bn);
    n_cmp++;
    if (ev_t.size() != 1 || (ev_t[0] - (t0 + 1)) != 3) begin
      n_err++;
      $display("FAIL read_latency: events %0d latency %0d, required 1 event latency 3",
               ev_t.size(), (ev_t.size() > 0) ? ev_t[0] - (t0 + 1) : -1);
    end
    n_cmp++;
    if (bn != 3) begin
      n_err++;
      $display("FAIL busy_width: got %0d cycles, required 3", bn);
    end
    n_cmp++;
    if (rd_data[2:0] !== 3'b101) begin
      n_err++;
      $display("FAIL read_data_hold: got %b, required 101", rd_data[2:0]);
    end
  endtask

  task automatic test_wb_priority();
    int bn;
    @(negedge clock);
    ev_t.delete();
    wb_req[1] = 1'b1; wb_addr[5:3] = 3'd2; wb_data[5:3] = 3'd4;
    rd_req[0] = 1'b1; rd_addr[2:0] = 3'd2;
    push_wb(1, 2, 3'd4);
    push_rd(0, 2);
    @(negedge clock);
    wb_req[1] = 1'b0; rd_req[0] = 1'b0;
    drain(30, bn);
    n_cmp++;
    if (ev_t.size() != 2 || (ev_t[1] - ev_t[0]) != 3) begin
      n_err++;
      $display("FAIL wb_then_rd_spacing: events %0d gap %0d, required 2 events gap 3",
               ev_t.size(), (ev_t.size() > 1) ? ev_t[1] - ev_t[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    int bn;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clock);
      ev_t.delete();
      rd_req = 3'b111;
      rd_addr = {3'd1, 3'd6, 3'd4};
      push_rd(0, 4); push_rd(1, 6); push_rd(2, 1);
      @(negedge clock);
      rd_req = 3'b000;
      drain(40, bn);
      n_cmp++;
      if (ev_t.size() != 3 || (ev_t[1] - ev_t[0]) != 3 || (ev_t[2] - ev_t[1]) != 3) begin
        n_err++;
        $display("FAIL rr_spacing: pass %0d events %0d, required 3 events spaced 3", rep, ev_t.size());
      end
    end
  endtask

  task automatic test_held_level();
    int bn;
    @(negedge clock);
    ev_t.delete();
    rd_req[2] = 1'b1; rd_addr[8:6] = 3'd7;
    push_rd(2, 7);
    repeat (6) @(negedge clock);
    rd_req[2] = 1'b0;
    drain(20, bn);
    repeat (5) @(negedge clock);
    n_cmp++;
    if (ev_t.size() != 1 || erro !== 3'b000) begin
      n_err++;
      $display("FAIL held_level: events %0d erro %b, required 1 event erro 000", ev_t.size(), erro);
    end
  endtask

  task automatic test_overflow();
    int bn;
    @(negedge clock);
    rd_req[0] = 1'b1; rd_addr[2:0] = 3'd0;
    push_rd(0, 0);
    @(negedge clock);
    rd_req[0] = 1'b0;
    wb_req[2] = 1'b1; wb_addr[8:6] = 3'd1; wb_data[8:6] = 3'd6;
    push_wb(2, 1, 3'd6);
    @(negedge clock);
    wb_req[2] = 1'b0;
    @(negedge clock);
    wb_req[2] = 1'b1; wb_data[8:6] = 3'd3;
    @(negedge clock);
    wb_req[2] = 1'b0;
    drain(30, bn);
    n_cmp++;
    if (erro !== 3'b100) begin
      n_err++;
      $display("FAIL overflow_erro: got %b, required 100", erro);
    end
    @(negedge clock);
    rd_req[1] = 1'b1; rd_addr[5:3] = 3'd1;
    push_rd(1, 1);
    @(negedge clock);
    rd_req[1] = 1'b0;
    drain(20, bn);
    n_cmp++;
    if (rd_data[5:3] !== 3'd6) begin
      n_err++;
      $display("FAIL overflow_data_kept: got %0d, required 6", rd_data[5:3]);
    end
  endtask

  task automatic test_reset_mid_read();
    int bn;
    @(negedge clock);
    wb_req[0] = 1'b1; wb_addr[2:0] = 3'd3; wb_data[2:0] = 3'd5;
    push_wb(0, 3, 3'd5);
    @(negedge clock);
    wb_req[0] = 1'b0;
    drain(20, bn);
    @(negedge clock);
    rd_req[2] = 1'b1; rd_addr[8:6] = 3'd3;
    push_rd(2, 3);
    @(negedge clock);
    rd_req[2] = 1'b0;
    drain(20, bn);
    // Now start a read and kill it while its counter is still at 1.
    @(negedge clock);
    rd_req[1] = 1'b1; rd_addr[5:3] = 3'd3;
    @(negedge clock);
    rd_req[1] = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_read_busy: got %b, required 1", busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rd_data, rd_valid, wb_done, erro, busy} !== 19'd0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %h, required 0", {rd_data, rd_valid, wb_done, erro, busy});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 3'(i);
    ev_t.delete();
    repeat (6) @(negedge clock);
    n_cmp++;
    if (ev_t.size() != 0) begin
      n_err++;
      $display("FAIL abandoned_read: got %0d pulses, required 0", ev_t.size());
    end
    @(negedge clock);
    rd_req[1] = 1'b1; rd_addr[5:3] = 3'd3;
    push_rd(1, 3);
    @(negedge clock);
    rd_req[1] = 1'b0;
    drain(20, bn);
    n_cmp++;
    if (rd_data[5:3] !== 3'd3) begin
      n_err++;
      $display("FAIL mem_reinit: got %0d, required 3", rd_data[5:3]);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_wb_priority();
    test_round_robin();
    test_held_level();
    test_overflow();
    test_reset_mid_read();
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controlador_memoria.md
# controlador_memoria

Shared main-memory controller on the bus side of the snooping MSI caches. Captures write-back and read-miss requests from the three processor caches, then serializes them with write-backs first and round-robin fairness. Commits write-backs to an 8-word × 3-bit memory and returns read data to the requesting cache after a fixed memory latency.

## Interface
Parameters:
- MEM_LAT, 2: memory access latency in cycles, legal range ≥1.
- NPROC, 3: number of processor ports. Fixed to 3 in this design.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- wb_req  in  3  per-processor write-back request; bit p = processor p.
- wb_addr  in  9  3-bit tag per port; port p uses [3p+2:3p].
- wb_data  in  9  3-bit block data per port, same packing as wb_addr.
- rd_req  in  3  per-processor memory read request.
- rd_addr  in  9  3-bit read address per port.
- rd_data  out  9  3-bit returned data per port; held until that port's next read completes.
- rd_valid  out  3  1-cycle pulse when rd_data[p] has been updated.
- wb_done  out  3  1-cycle pulse when port p's write-back has been committed.
- erro  out  3  sticky per-port bit for a request dropped on overflow.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Request capture:
  - Requests are rising-edge detected against a registered copy of wb_req/rd_req. A level held for many cycles counts as one request.
  - On a detected edge, the port's address (and data for write-backs) is latched and wb_pend[p] or rd_pend[p] is set.
  - An edge on port p while the same-kind pend[p] is already set is ignored and sets erro[p]. The latched values are unchanged.
- Arbitration, evaluated in IDLE only:
  - If any wb_pend is set, grant a write-back. Otherwise, if any rd_pend is set, grant a read.
  - Within the chosen class, grant the first pending port at or after rr_ptr, in the order ptr, ptr+1, ptr+2 mod 3.
  - After a grant, rr_ptr = (granted+1) mod 3.
  - The grant clears that port's pend bit.
  - Because write-backs have priority, a modified block evicted or flushed by a snooping receiver reaches memory before any competing read is serviced.
- FSM states:
  - IDLE: go to WRITE on a write-back grant, to READ on a read grant.
  - WRITE: count from MEM_LAT-1 down to 0. At 0, write mem[addr]=data, pulse wb_done[p], return to IDLE.
  - READ: count from MEM_LAT-1 down to 0. At 0, load rd_data[p]=mem[addr], pulse rd_valid[p], return to IDLE.
- A request captured in the same cycle the FSM returns to IDLE is eligible for grant on the next cycle.
- Write-back and read edges from the same port in the same cycle are both latched. The write-back is serviced first.
- Read and write-back to the same address from different ports: the write-back is serviced first, so the read returns the new data.

## Timing
- Reset, asynchronous: clears FSM to IDLE, counter=0, rr_ptr=0, all pend bits, edge-detect registers, rd_data=0, rd_valid=0, wb_done=0, erro=0, busy=0. Memory is reinitialized to mem[i]=i, 3-bit.
- Reset mid-operation: the in-flight access is abandoned, with no commit and no pulse.
- Uncontended latency: request edge sampled at posedge N; grant and leave IDLE at N+1; commit and pulse at N+1+MEM_LAT.
- Back-to-back service: there is 1 idle cycle between consecutive accesses, so throughput is one access per MEM_LAT+1 cycles.
- busy is high from the grant edge through the commit edge inclusive.
- rd_valid and wb_done are exactly 1 cycle wide. Pulses for different ports never coincide.

## Structure
- Package mem_pkg holds:
  - NPROC=3, ADDR_W=3, DATA_W=3.
  - Memory depth 8.
  - FSM state enum {IDLE, WRITE, READ}.
- Sub-module arbitro_rr: combinational 3-way round-robin picker.
  - Inputs: pending vector and ptr.
  - Outputs: grant one-hot and any.
  - Instantiated twice, once for write-backs and once for reads.

## Test plan
All scenarios use MEM_LAT=2.
1. After reset, rd_req[0] pulse with addr 5 → rd_valid[0] 3 cycles after sampling; rd_data[2:0]=3'b101; busy high 3 cycles.
2. Same cycle: wb_req[1] addr 2 data 4 and rd_req[0] addr 2 → wb_done[1] first, then rd_valid[0] 3 cycles later with rd_data[2:0]=3'b100.
3. rd_req on all three ports in one cycle after reset → rd_valid order port 0, 1, 2, spaced 3 cycles apart. Then a fresh triple → order 0, 1, 2 again.
4. rd_req[2] held high 6 cycles, addr 7 → exactly one rd_valid[2] with data 3'b111; erro stays 0.
5. wb_req[2] addr 1 data 6, then before service a second wb_req[2] edge with data 3 → erro[2]=1; a later read of addr 1 returns 6.
6. Assert reset during READ (counter=1) → all outputs 0 immediately, no rd_valid follows, and mem[3] reads back 3 afterwards.
